conv_out_writer: RTL and testbench
==================================

# conv_out_writer

Consumer end of the `conv_blk` result stream. Accepts the raster-ordered 48-bit signed results that `conv_blk` qualifies with `o_en` and turns them into write transactions for the output feature-map BRAM, incrementing the write address per stored word. When MAXPOOL=1 it also applies a 2x2, stride-2 max-pool on the fly before writing. It sits between `conv_blk` and the output `bram` instance in the convolutional layer datapath.

## Interface
Parameters:
- KERNEL_SIZE, 1, kernel side.
- FM_SIZE, 4, input feature-map side.
- PADDING, 0, padding per edge.
- STRIDE, 1, convolution stride.
- MAXPOOL, 1, 1 = 2x2/stride-2 max-pool before storage; 0 = store every result.
- DATA_WIDTH, 48, result width (DSP accumulator width).
- Localparams:
  - OUT_SIZE = ((FM_SIZE-KERNEL_SIZE+2*PADDING)/STRIDE)+1.
  - POOL_SIZE = OUT_SIZE/2 (floor).
  - DEPTH = MAXPOOL ? POOL_SIZE² : OUT_SIZE².
  - ADDR_WIDTH = max(1, $clog2(DEPTH)).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  one-cycle pulse that arms a new frame.
- i_en  in  1  sample valid; connects to `conv_blk` o_en.
- i_data  in  DATA_WIDTH  signed result; connects to `conv_blk` o_conv_result.
- o_wr_en  out  1  BRAM write strobe.
- o_wr_addr  out  ADDR_WIDTH  BRAM write address.
- o_wr_data  out  DATA_WIDTH  BRAM write data (signed).
- o_busy  out  1  high while a frame is being collected.
- o_done  out  1  one-cycle pulse at frame end.

## Operation
- FSM with three states: IDLE, COLLECT, DONE.
  - IDLE: i_start moves to COLLECT and clears the row/col counters, the pair register and the row-buffer valid state.
  - COLLECT: every cycle with i_en=1 accepts one sample at position (row, col), raster order, col fastest. Cycles with i_en=0 are bubbles and change nothing.
  - The sample that completes OUT_SIZE² accepted samples moves the FSM to DONE.
  - DONE: lasts one cycle, then returns to IDLE.
- i_en is ignored in IDLE and DONE. A sample arriving in the same cycle as i_start while in IDLE is ignored.
- i_start during COLLECT restarts the frame: counters and pool state are cleared, the sample in that cycle is discarded, and no write is issued for the aborted frame.
- MAXPOOL=0: each accepted sample is written unchanged, with o_wr_addr = row*OUT_SIZE+col.
- MAXPOOL=1, non-overlapping 2x2 windows, floor behaviour:
  - Samples with row = OUT_SIZE-1 or col = OUT_SIZE-1 are counted but dropped when OUT_SIZE is odd.
  - Even col: the sample is held in a pair register.
  - Odd col, even row: max(pair, sample) goes to row buffer entry col/2 (POOL_SIZE entries).
  - Odd col, odd row: write max(rowbuf[col/2], pair, sample) to address (row/2)*POOL_SIZE + col/2.
- All comparisons are signed, full DATA_WIDTH, with no truncation. On ties, any equal operand may be chosen.
- Write addresses are produced in strictly increasing order from 0 to DEPTH-1, one write per stored word. No wrap-around within a frame.
- Degenerate case, MAXPOOL=1 with OUT_SIZE=1 (DEPTH=0): no writes occur, but o_done still pulses.

## Timing
- Reset (async assert): state=IDLE; o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=0, o_done=0; counters and pool state cleared.
- All outputs are registered.
- o_wr_en/o_wr_addr/o_wr_data appear 1 cycle after the edge on which the completing sample is accepted. They are valid for exactly 1 cycle per write.
- o_busy=1 from the cycle after i_start is sampled until the cycle after the final sample is accepted; it is low in DONE.
- o_done=1 only in the DONE cycle, which is 1 cycle after the final sample is accepted.
  - MAXPOOL=0: this is the same cycle as the last o_wr_en.
  - MAXPOOL=1 with even OUT_SIZE: also the same cycle as the last o_wr_en.
  - MAXPOOL=1 with odd OUT_SIZE: the last write occurs earlier.
- Throughput: 1 sample per cycle sustained, with back-to-back i_en and no stall output.
- A reset asserted mid-frame aborts immediately; the next frame requires a fresh i_start.

## Test plan
- MAXPOOL=0, FM_SIZE=4, KERNEL_SIZE=1; i_start, then samples 0..15 on consecutive cycles -> 16 writes, addr n = data n. The last write and o_done coincide 1 cycle after sample 15; o_busy falls with it.
- MAXPOOL=1, same geometry, samples 1..16 -> writes (0,6), (1,8), (2,14), (3,16), then o_done in the same cycle as the addr-3 write.
- MAXPOOL=1, samples -1..-16 with random i_en bubbles -> writes (0,-1), (1,-3), (2,-9), (3,-11); no write during bubbles.
- MAXPOOL=1, FM_SIZE=5 (OUT_SIZE=5), samples 1..25 -> writes (0,7), (1,9), (2,17), (3,19); o_done 1 cycle after sample 25; row 4 and col 4 produce no writes.
- Assert i_rst after sample 6 of a frame -> all outputs 0 asynchronously. Then i_start plus 16 samples -> a clean complete frame starting at addr 0.
- i_start again after sample 9 of a frame, then 16 samples -> writes only from the new frame, addresses starting at 0; exactly one o_done.

Source files
------------

// File: rtl/conv_out_writer.sv
// Output-side writer for the conv_blk result stream: turns raster-ordered results into
// sequential BRAM writes, optionally reducing them with a 2x2 stride-2 max-pool first.
module conv_out_writer #(
    parameter int KERNEL_SIZE = 1,
    parameter int FM_SIZE     = 4,
    parameter int PADDING     = 0,
    parameter int STRIDE      = 1,
    parameter int MAXPOOL     = 1,
    parameter int DATA_WIDTH  = 48,
    localparam int OUT_SIZE   = ((FM_SIZE - KERNEL_SIZE + 2 * PADDING) / STRIDE) + 1,
    localparam int POOL_SIZE  = OUT_SIZE / 2,
    localparam int DEPTH      = (MAXPOOL != 0) ? POOL_SIZE * POOL_SIZE : OUT_SIZE * OUT_SIZE,
    localparam int ADDR_WIDTH = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic                         i_en,
    input  logic signed [DATA_WIDTH-1:0] i_data,
    output logic                         o_wr_en,
    output logic        [ADDR_WIDTH-1:0] o_wr_addr,
    output logic signed [DATA_WIDTH-1:0] o_wr_data,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int CW  = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam int RB  = (POOL_SIZE > 0) ? POOL_SIZE : 1;
    localparam int RBW = (RB > 1) ? $clog2(RB) : 1;
    localparam logic [CW-1:0] LAST = CW'(OUT_SIZE - 1);
    localparam bit OUT_ODD = (OUT_SIZE % 2) == 1;

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t                         state_q;
    logic        [CW-1:0]           row_q;
    logic        [CW-1:0]           col_q;
    logic        [ADDR_WIDTH-1:0]   next_addr_q;
    logic signed [DATA_WIDTH-1:0]   pair_q;
    logic signed [DATA_WIDTH-1:0]   rowbuf_q [RB];
    logic                           wr_en_q;
    logic        [ADDR_WIDTH-1:0]   wr_addr_q;
    logic signed [DATA_WIDTH-1:0]   wr_data_q;
    logic                           busy_q;
    logic                           done_q;

    logic        [RBW-1:0]          rb_idx;
    logic signed [DATA_WIDTH-1:0]   pair_max_d;
    logic signed [DATA_WIDTH-1:0]   win_max_d;
    logic                           is_last;
    logic                           in_window;

    assign rb_idx     = RBW'(col_q >> 1);
    assign pair_max_d = (i_data > pair_q) ? i_data : pair_q;
    assign win_max_d  = (pair_max_d > rowbuf_q[rb_idx]) ? pair_max_d : rowbuf_q[rb_idx];
    assign is_last    = (row_q == LAST) && (col_q == LAST);
    // With an odd output side the last row and column have no partner and fall outside every window.
    assign in_window  = !(OUT_ODD && ((row_q == LAST) || (col_q == LAST)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            next_addr_q <= '0;
            pair_q      <= '0;
            for (int i = 0; i < RB; i++) rowbuf_q[i] <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        state_q     <= COLLECT;
                        busy_q      <= 1'b1;
                        row_q       <= '0;
                        col_q       <= '0;
                        next_addr_q <= '0;
                        pair_q      <= '0;
                    end
                end
                COLLECT: begin
                    if (i_start) begin
                        row_q       <= '0;
                        col_q       <= '0;
                        next_addr_q <= '0;
                        pair_q      <= '0;
                    end else if (i_en) begin
                        if (MAXPOOL == 0) begin
                            wr_en_q     <= 1'b1;
                            wr_addr_q   <= next_addr_q;
                            wr_data_q   <= i_data;
                            next_addr_q <= next_addr_q + ADDR_WIDTH'(1);
                        end else if (in_window) begin
                            if (!col_q[0]) begin
                                pair_q <= i_data;
                            end else if (!row_q[0]) begin
                                rowbuf_q[rb_idx] <= pair_max_d;
                            end else begin
                                wr_en_q     <= 1'b1;
                                wr_addr_q   <= next_addr_q;
                                wr_data_q   <= win_max_d;
                                next_addr_q <= next_addr_q + ADDR_WIDTH'(1);
                            end
                        end
                        if (col_q == LAST) begin
                            col_q <= '0;
                            row_q <= row_q + CW'(1);
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                        if (is_last) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_wr_en   = wr_en_q;
    assign o_wr_addr = wr_addr_q;
    assign o_wr_data = wr_data_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;

endmodule

// File: tb/tb_conv_out_writer.sv
// Directed bench for conv_out_writer: one pass-through instance and two max-pool instances
// (even and odd output side), each fed hand-built raster streams.
module tb_conv_out_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;
    logic start [3];
    logic en [3];
    logic signed [47:0] din [3];

    logic wr_en0, wr_en1, wr_en2, busy0, busy1, busy2, done0, done1, done2;
    logic [3:0] addr0;
    logic [1:0] addr1, addr2;
    logic signed [47:0] wd0, wd1, wd2;

    conv_out_writer #(.KERNEL_SIZE(1), .FM_SIZE(4), .PADDING(0), .STRIDE(1), .MAXPOOL(0), .DATA_WIDTH(48)) u_np (
        .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_en(en[0]), .i_data(din[0]),
        .o_wr_en(wr_en0), .o_wr_addr(addr0), .o_wr_data(wd0), .o_busy(busy0), .o_done(done0));

    conv_out_writer #(.KERNEL_SIZE(1), .FM_SIZE(4), .PADDING(0), .STRIDE(1), .MAXPOOL(1), .DATA_WIDTH(48)) u_p4 (
        .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_en(en[1]), .i_data(din[1]),
        .o_wr_en(wr_en1), .o_wr_addr(addr1), .o_wr_data(wd1), .o_busy(busy1), .o_done(done1));

    conv_out_writer #(.KERNEL_SIZE(1), .FM_SIZE(5), .PADDING(0), .STRIDE(1), .MAXPOOL(1), .DATA_WIDTH(48)) u_p5 (
        .i_clk(clk), .i_rst(rst), .i_start(start[2]), .i_en(en[2]), .i_data(din[2]),
        .o_wr_en(wr_en2), .o_wr_addr(addr2), .o_wr_data(wd2), .o_busy(busy2), .o_done(done2));

    logic mon_en [3];
    logic mon_busy [3];
    logic mon_done [3];
    int mon_addr [3];
    logic signed [47:0] mon_data [3];

    assign mon_en[0] = wr_en0;  assign mon_en[1] = wr_en1;  assign mon_en[2] = wr_en2;
    assign mon_busy[0] = busy0; assign mon_busy[1] = busy1; assign mon_busy[2] = busy2;
    assign mon_done[0] = done0; assign mon_done[1] = done1; assign mon_done[2] = done2;
    assign mon_addr[0] = int'(addr0); assign mon_addr[1] = int'(addr1); assign mon_addr[2] = int'(addr2);
    assign mon_data[0] = wd0;   assign mon_data[1] = wd1;   assign mon_data[2] = wd2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic en_edge [3];
    int addr_q [3][$];
    logic signed [47:0] data_q [3][$];
    int done_cnt [3];
    int done_cyc [3];
    int last_wr_cyc [3];
    int bubble_wr [3];
    logic done_busy [3];

    // Edge-side bookkeeping: cycle count and the i_en value each instance saw at the edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) en_edge[i] <= en[i];
    end

    // Write/done logger sampled mid-cycle; the test tasks judge what it collected.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (mon_en[i]) begin
                addr_q[i].push_back(mon_addr[i]);
                data_q[i].push_back(mon_data[i]);
                last_wr_cyc[i] = cyc;
                if (!en_edge[i]) bubble_wr[i]++;
            end
            if (mon_done[i]) begin
                done_cnt[i]++;
                done_cyc[i]  = cyc;
                done_busy[i] = mon_busy[i];
            end
        end
    end

    task automatic clear_log(input int d);
        addr_q[d].delete();
        data_q[d].delete();
        done_cnt[d]  = 0;
        done_cyc[d]  = -1;
        last_wr_cyc[d] = -1;
        bubble_wr[d] = 0;
    endtask

    task automatic put(input int d, input logic signed [47:0] v, input logic e);
        en[d]  = e;
        din[d] = v;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int d);
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++; if (wr_en1 !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %0b want 0", wr_en1); end
        checks++; if (addr1 !== 2'd0) begin errors++; $display("FAIL reset_wr_addr got %0d want 0", addr1); end
        checks++; if (wd1 !== 48'sd0) begin errors++; $display("FAIL reset_wr_data got %0d want 0", wd1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done1); end
        #5 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_idle_ignore();
        clear_log(0);
        for (int n = 0; n < 3; n++) put(0, 48'(n + 40), 1'b1);
        en[0] = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (addr_q[0].size() != 0) begin errors++; $display("FAIL idle_ignore writes got %0d want 0", addr_q[0].size()); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL idle_ignore busy got %0b want 0", busy0); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_nopool();
        int acc;
        clear_log(0);
        pulse_start(0);
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL nopool_busy_rise got %0b want 1", busy0); end
        for (int n = 0; n < 16; n++) put(0, 48'(n), 1'b1);
        en[0] = 1'b0;
        acc = cyc;
        repeat (3) @(negedge clk);
        checks++; if (addr_q[0].size() != 16) begin errors++; $display("FAIL nopool_count got %0d want 16", addr_q[0].size()); end
        for (int i = 0; i < addr_q[0].size() && i < 16; i++) begin
            checks++;
            if (addr_q[0][i] != i || data_q[0][i] !== 48'(i)) begin
                errors++; $display("FAIL nopool_write[%0d] got (%0d,%0d) want (%0d,%0d)", i, addr_q[0][i], data_q[0][i], i, i);
            end
        end
        checks++; if (done_cnt[0] != 1) begin errors++; $display("FAIL nopool_done_count got %0d want 1", done_cnt[0]); end
        checks++; if (done_cyc[0] != acc) begin errors++; $display("FAIL nopool_done_cycle got %0d want %0d", done_cyc[0], acc); end
        checks++; if (last_wr_cyc[0] != acc) begin errors++; $display("FAIL nopool_last_write_cycle got %0d want %0d", last_wr_cyc[0], acc); end
        checks++; if (done_busy[0] !== 1'b0) begin errors++; $display("FAIL nopool_busy_at_done got %0b want 0", done_busy[0]); end
    endtask

    task automatic test_pool_even();
        int acc;
        int ea [4] = '{0, 1, 2, 3};
        int ed [4] = '{6, 8, 14, 16};
        clear_log(1);
        pulse_start(1);
        for (int n = 1; n <= 16; n++) put(1, 48'(n), 1'b1);
        en[1] = 1'b0;
        acc = cyc;
        repeat (3) @(negedge clk);
        checks++; if (addr_q[1].size() != 4) begin errors++; $display("FAIL pool4_count got %0d want 4", addr_q[1].size()); end
        for (int i = 0; i < addr_q[1].size() && i < 4; i++) begin
            checks++;
            if (addr_q[1][i] != ea[i] || data_q[1][i] !== 48'(ed[i])) begin
                errors++; $display("FAIL pool4_write[%0d] got (%0d,%0d) want (%0d,%0d)", i, addr_q[1][i], data_q[1][i], ea[i], ed[i]);
            end
        end
        checks++; if (done_cnt[1] != 1) begin errors++; $display("FAIL pool4_done_count got %0d want 1", done_cnt[1]); end
        checks++; if (done_cyc[1] != acc || last_wr_cyc[1] != acc) begin
            errors++; $display("FAIL pool4_done_align done %0d last_write %0d want %0d", done_cyc[1], last_wr_cyc[1], acc);
        end
    endtask

    task automatic test_bubbles();
        int acc;
        int mask = 'h8864;
        int ea [4] = '{0, 1, 2, 3};
        int ed [4] = '{-1, -3, -9, -11};
        clear_log(1);
        pulse_start(1);
        for (int k = 0; k < 16; k++) begin
            if (mask[k]) put(1, 48'sd999, 1'b0);
            put(1, 48'(-(k + 1)), 1'b1);
        end
        en[1] = 1'b0;
        acc = cyc;
        repeat (3) @(negedge clk);
        checks++; if (addr_q[1].size() != 4) begin errors++; $display("FAIL bubble_count got %0d want 4", addr_q[1].size()); end
        for (int i = 0; i < addr_q[1].size() && i < 4; i++) begin
            checks++;
            if (addr_q[1][i] != ea[i] || data_q[1][i] !== 48'(ed[i])) begin
                errors++; $display("FAIL bubble_write[%0d] got (%0d,%0d) want (%0d,%0d)", i, addr_q[1][i], data_q[1][i], ea[i], ed[i]);
            end
        end
        checks++; if (bubble_wr[1] != 0) begin errors++; $display("FAIL bubble_idle_writes got %0d want 0", bubble_wr[1]); end
        checks++; if (done_cnt[1] != 1 || done_cyc[1] != acc) begin
            errors++; $display("FAIL bubble_done got count %0d cycle %0d want 1 at %0d", done_cnt[1], done_cyc[1], acc);
        end
    endtask

    task automatic test_pool_odd();
        int acc;
        int ea [4] = '{0, 1, 2, 3};
        int ed [4] = '{7, 9, 17, 19};
        clear_log(2);
        pulse_start(2);
        for (int n = 1; n <= 25; n++) put(2, 48'(n), 1'b1);
        en[2] = 1'b0;
        acc = cyc;
        repeat (3) @(negedge clk);
        checks++; if (addr_q[2].size() != 4) begin errors++; $display("FAIL pool5_count got %0d want 4", addr_q[2].size()); end
        for (int i = 0; i < addr_q[2].size() && i < 4; i++) begin
            checks++;
            if (addr_q[2][i] != ea[i] || data_q[2][i] !== 48'(ed[i])) begin
                errors++; $display("FAIL pool5_write[%0d] got (%0d,%0d) want (%0d,%0d)", i, addr_q[2][i], data_q[2][i], ea[i], ed[i]);
            end
        end
        checks++; if (done_cnt[2] != 1 || done_cyc[2] != acc) begin
            errors++; $display("FAIL pool5_done got count %0d cycle %0d want 1 at %0d", done_cnt[2], done_cyc[2], acc);
        end
        checks++; if (last_wr_cyc[2] != acc - 6) begin errors++; $display("FAIL pool5_last_write_cycle got %0d want %0d", last_wr_cyc[2], acc - 6); end
    endtask

    task automatic test_reset_midframe();
        int acc;
        int ed [4] = '{6, 8, 14, 16};
        clear_log(1);
        pulse_start(1);
        for (int n = 1; n <= 6; n++) put(1, 48'(n), 1'b1);
        en[1] = 1'b0;
        checks++; if (wr_en1 !== 1'b1 || wd1 !== 48'sd6) begin errors++; $display("FAIL midreset_pre_write got (%0b,%0d) want (1,6)", wr_en1, wd1); end
        #2 rst = 1'b1;
        #1;
        checks++; if (wr_en1 !== 1'b0 || addr1 !== 2'd0 || wd1 !== 48'sd0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs got en %0b addr %0d data %0d busy %0b done %0b want all 0", wr_en1, addr1, wd1, busy1, done1);
        end
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        clear_log(1);
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL midreset_stays_idle busy got %0b want 0", busy1); end
        pulse_start(1);
        for (int n = 1; n <= 16; n++) put(1, 48'(n), 1'b1);
        en[1] = 1'b0;
        acc = cyc;
        repeat (3) @(negedge clk);
        checks++; if (addr_q[1].size() != 4) begin errors++; $display("FAIL midreset_count got %0d want 4", addr_q[1].size()); end
        for (int i = 0; i < addr_q[1].size() && i < 4; i++) begin
            checks++;
            if (addr_q[1][i] != i || data_q[1][i] !== 48'(ed[i])) begin
                errors++; $display("FAIL midreset_write[%0d] got (%0d,%0d) want (%0d,%0d)", i, addr_q[1][i], data_q[1][i], i, ed[i]);
            end
        end
        checks++; if (done_cnt[1] != 1 || done_cyc[1] != acc) begin
            errors++; $display("FAIL midreset_done got count %0d cycle %0d want 1 at %0d", done_cnt[1], done_cyc[1], acc);
        end
    endtask

    task automatic test_restart();
        int acc;
        int ed [4] = '{106, 108, 114, 116};
        clear_log(1);
        pulse_start(1);
        for (int n = 1; n <= 9; n++) put(1, 48'(n), 1'b1);
        clear_log(1);
        start[1] = 1'b1;
        put(1, 48'sd500, 1'b1);
        start[1] = 1'b0;
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL restart_busy got %0b want 1", busy1); end
        for (int n = 101; n <= 116; n++) put(1, 48'(n), 1'b1);
        en[1] = 1'b0;
        acc = cyc;
        repeat (3) @(negedge clk);
        checks++; if (addr_q[1].size() != 4) begin errors++; $display("FAIL restart_count got %0d want 4", addr_q[1].size()); end
        for (int i = 0; i < addr_q[1].size() && i < 4; i++) begin
            checks++;
            if (addr_q[1][i] != i || data_q[1][i] !== 48'(ed[i])) begin
                errors++; $display("FAIL restart_write[%0d] got (%0d,%0d) want (%0d,%0d)", i, addr_q[1][i], data_q[1][i], i, ed[i]);
            end
        end
        checks++; if (done_cnt[1] != 1 || done_cyc[1] != acc) begin
            errors++; $display("FAIL restart_done got count %0d cycle %0d want 1 at %0d", done_cnt[1], done_cyc[1], acc);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            en[i]    = 1'b0;
            din[i]   = '0;
            done_cnt[i] = 0;
            bubble_wr[i] = 0;
        end
        #1;
        test_reset();
        test_idle_ignore();
        test_nopool();
        test_pool_even();
        test_bubbles();
        test_pool_odd();
        test_reset_midframe();
        test_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
